alu_share_arbiter: RTL and testbench

- Shares the single combinational ALU between NREQ requesters, e.g. the EX-stage datapath and a branch/address helper unit.
- Arbitrates round-robin and drives the ALU operand, opcode and PC inputs from the winning requester.
- Registers the ALU result and zero flag, then returns them to the winner over a valid/ready response channel.
- Sits between the requesters and the ALU instance; throughput is one operation per cycle.

---
 rtl/alu_share_arbiter_pkg.sv | 26 ++
 rtl/alu_share_arbiter_rr_pick.sv | 30 +++
 rtl/alu_share_arbiter.sv | 119 +++++++++++
 tb/tb_alu_share_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: opcode codes used by the ALU
// and the arbiter state encoding.
package alu_share_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_SLL   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_AUIPC = 5'd7;

  localparam int CNT_W = 16;

  // Index width that stays legal when there is only one requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, with
// wrap-around. Returns a one-hot grant, its encoded index and an any flag.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        grant[j] = 1'b1;
        idx      = IW'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NREQ requesters: round-robin grant,
// registered result returned to the winner over a valid/ready channel.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   ARB_IDLE | no result held
//   ARB_HOLD | result held for requester rsp_id
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter  int NREQ = 2,
  parameter  int DW   = 32,
  parameter  int OPW  = 5,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*DW-1:0]    req_a,
  input  logic [NREQ*DW-1:0]    req_b,
  input  logic [NREQ*OPW-1:0]   req_op,
  input  logic [NREQ*DW-1:0]    req_pc,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [DW-1:0]         rsp_c,
  output logic [7:0]            rsp_zero,
  output logic [IW-1:0]         rsp_id,
  output logic [DW-1:0]         alu_a,
  output logic [DW-1:0]         alu_b,
  output logic [OPW-1:0]        alu_op,
  output logic [DW-1:0]        alu_pc,
  input  logic [DW-1:0]         alu_c,
  input  logic [7:0]            alu_zero,
  output logic [NREQ*CNT_W-1:0] grant_cnt
);

  arb_state_t           state, state_nxt;
  logic [IW-1:0]        rr_ptr, rr_ptr_nxt;
  logic [IW-1:0]        win_idx;
  logic [NREQ-1:0]      win_onehot;
  logic                 any_req;
  logic                 can_accept;
  logic                 win;
  logic [NREQ*CNT_W-1:0] cnt_nxt;

  rr_pick #(
    .N (NREQ),
    .IW(IW)
  ) u_rr_pick (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .grant(win_onehot),
    .idx  (win_idx),
    .any  (any_req)
  );

  // Holding a result still admits a new request when the owner drains it this cycle.
  always_comb begin
    can_accept = (state == ARB_IDLE) || rsp_ready[rsp_id];
    win        = rstn && can_accept && any_req;
    req_ready  = win ? win_onehot : '0;

    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    alu_pc = '0;
    if (win) begin
      alu_a  = req_a[int'(win_idx)*DW +: DW];
      alu_b  = req_b[int'(win_idx)*DW +: DW];
      alu_op = req_op[int'(win_idx)*OPW +: OPW];
      alu_pc = req_pc[int'(win_idx)*DW +: DW];
    end

    rsp_valid = '0;
    if (state == ARB_HOLD) rsp_valid[rsp_id] = 1'b1;
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    cnt_nxt    = grant_cnt;
    if (win) begin
      state_nxt  = ARB_HOLD;
      rr_ptr_nxt = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (win_onehot[i] && (grant_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
          cnt_nxt[i*CNT_W +: CNT_W] = grant_cnt[i*CNT_W +: CNT_W] + 1'b1;
      end
    end else if ((state == ARB_HOLD) && rsp_ready[rsp_id]) begin
      state_nxt = ARB_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      grant_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      grant_cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_c    <= '0;
      rsp_zero <= '0;
      rsp_id   <= '0;
    end else if (win) begin
      rsp_c    <= alu_c;
      rsp_zero <= alu_zero;
      rsp_id   <= win_idx;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter with two requesters and a behavioural ALU stub.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int OPW  = 5;

  logic              clk = 1'b0;
  logic              rstn;
  logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [63:0]       req_a, req_b, req_pc;
  logic [9:0]        req_op;
  logic [31:0]       rsp_c, alu_a, alu_b, alu_pc, alu_c;
  logic [7:0]        rsp_zero, alu_zero;
  logic [0:0]        rsp_id;
  logic [4:0]        alu_op;
  logic [31:0]       grant_cnt;

  logic [31:0] fa [2];
  logic [31:0] fb [2];
  logic [31:0] fpc [2];
  logic [4:0]  fop [2];

  int n_pass = 0;
  int n_total = 0;

  bit          m_hold;
  int          m_owner, m_ptr, last_win;
  logic [31:0] m_c;
  logic [7:0]  m_z;
  int          m_cnt [2];

  always #5 clk = ~clk;

  assign req_a  = {fa[1], fa[0]};
  assign req_b  = {fb[1], fb[0]};
  assign req_pc = {fpc[1], fpc[0]};
  assign req_op = {fop[1], fop[0]};

  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] pc);
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_AND:   return a & b;
      ALU_OR:    return a | b;
      ALU_XOR:   return a ^ b;
      ALU_SLL:   return a << b[4:0];
      ALU_SRL:   return a >> b[4:0];
      ALU_AUIPC: return pc + b;
      default:   return 32'hFFFF_FFFF;
    endcase
  endfunction

  assign alu_c    = ref_alu(alu_op, alu_a, alu_b, alu_pc);
  assign alu_zero = {7'd0, (alu_c == 32'd0)};

  alu_share_arbiter #(.NREQ(NREQ), .DW(DW), .OPW(OPW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_c(rsp_c), .rsp_zero(rsp_zero), .rsp_id(rsp_id),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_pc(alu_pc),
    .alu_c(alu_c), .alu_zero(alu_zero), .grant_cnt(grant_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic set_req(input int id, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc);
    fop[id] = op; fa[id] = a; fb[id] = b; fpc[id] = pc;
  endtask

  // One clock: apply inputs, check the combinational side, then the registered side.
  task automatic cycle(input logic [1:0] rv, input logic [1:0] rr);
    int  w;
    bit  can;
    req_valid = rv;
    rsp_ready = rr;
    #1;
    can = !m_hold || rr[m_owner];
    w = -1;
    if (can)
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && rv[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    chk("req_ready", 64'(req_ready), (w >= 0) ? 64'(1 << w) : 64'd0);
    if (w >= 0) begin
      chk("alu_a", 64'(alu_a), 64'(fa[w]));
      chk("alu_op", 64'(alu_op), 64'(fop[w]));
    end else begin
      chk("alu_idle", 64'(alu_a | alu_b | alu_pc | 32'(alu_op)), 64'd0);
    end
    last_win = w;
    @(posedge clk);
    #1;
    if (w >= 0) begin
      m_hold  = 1'b1;
      m_owner = w;
      m_c     = ref_alu(fop[w], fa[w], fb[w], fpc[w]);
      m_z     = (m_c == 32'd0) ? 8'd1 : 8'd0;
      m_ptr   = (w + 1) % NREQ;
      if (m_cnt[w] < 65535) m_cnt[w]++;
    end else if (m_hold && rr[m_owner]) begin
      m_hold = 1'b0;
    end
    chk("rsp_valid", 64'(rsp_valid), m_hold ? 64'(1 << m_owner) : 64'd0);
    chk("rsp_c", 64'(rsp_c), 64'(m_c));
    chk("rsp_zero", 64'(rsp_zero), 64'(m_z));
    chk("rsp_id", 64'(rsp_id), 64'(m_owner));
    chk("grant_cnt", 64'(grant_cnt), {32'd0, m_cnt[1][15:0], m_cnt[0][15:0]});
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_grant_cnt", 64'(grant_cnt), 64'd0);
    chk("rst_rsp_c", 64'(rsp_c), 64'd0);
    m_hold = 1'b0; m_owner = 0; m_ptr = 0; m_c = '0; m_z = '0;
    m_cnt[0] = 0; m_cnt[1] = 0;
    req_valid = 2'b00;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          id;
    logic [4:0]  op;
    logic [31:0] a, b, pc;
    logic [31:0] exp_c;
    logic [7:0]  exp_z;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{0, ALU_ADD,   32'd5,      32'd3,      32'h0,  32'd8,          8'd0};
    tbl[1] = '{1, ALU_SUB,   32'd7,      32'd7,      32'h0,  32'd0,          8'd1};
    tbl[2] = '{0, ALU_AUIPC, 32'd0,      32'h1000,   32'h80, 32'h1080,       8'd0};
    tbl[3] = '{1, ALU_AND,   32'hF0F0,   32'h0FF0,   32'h0,  32'h00F0,       8'd0};
    tbl[4] = '{0, ALU_XOR,   32'hFF,     32'hFF,     32'h0,  32'd0,          8'd1};
    tbl[5] = '{1, ALU_SLL,   32'd1,      32'd4,      32'h0,  32'd16,         8'd0};
    tbl[6] = '{0, 5'd31,     32'd1,      32'd2,      32'h0,  32'hFFFF_FFFF,  8'd0};

    for (int i = 0; i < 2; i++) set_req(i, ALU_ADD, 32'd0, 32'd0, 32'd0);
    do_reset();

    // Single operations, one at a time, each drained before the next.
    for (int i = 0; i < 7; i++) begin
      set_req(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].pc);
      cycle(2'(1 << tbl[i].id), 2'b00);
      chk("tbl_c", 64'(rsp_c), 64'(tbl[i].exp_c));
      chk("tbl_zero", 64'(rsp_zero), 64'(tbl[i].exp_z));
      chk("tbl_id", 64'(rsp_id), 64'(tbl[i].id));
      if (i == 1) chk("tbl_cnt1", 64'(grant_cnt[31:16]), 64'd1);
      cycle(2'b00, 2'(1 << tbl[i].id));
      chk("tbl_drain", 64'(rsp_valid), 64'd0);
    end

    // Contention from reset: grants alternate 0,1,0,1,...
    do_reset();
    set_req(0, ALU_ADD, 32'd10, 32'd1, 32'd0);
    set_req(1, ALU_SUB, 32'd10, 32'd1, 32'd0);
    for (int i = 0; i < 6; i++) begin
      cycle(2'b11, 2'b11);
      chk("rr_order", 64'(last_win), 64'(i % 2));
    end
    cycle(2'b00, 2'b11);

    // Backpressure: req0 result held 4 cycles while req1 waits.
    set_req(0, ALU_OR, 32'h1200, 32'h0034, 32'd0);
    cycle(2'b01, 2'b00);
    for (int i = 0; i < 4; i++) begin
      cycle(2'b10, 2'b10);
      chk("bp_held_c", 64'(rsp_c), 64'h1234);
    end
    cycle(2'b10, 2'b01);
    chk("bp_grant1", 64'(last_win), 64'd1);
    cycle(2'b00, 2'b10);

    // Async reset while a result is held.
    set_req(0, ALU_ADD, 32'd1, 32'd1, 32'd0);
    cycle(2'b01, 2'b00);
    chk("hold_before_rst", 64'(rsp_valid), 64'd1);
    do_reset();
    set_req(1, ALU_ADD, 32'd2, 32'd2, 32'd0);
    cycle(2'b10, 2'b00);
    chk("post_rst_grant1", 64'(last_win), 64'd1);
    cycle(2'b00, 2'b10);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++)
        set_req(i, 5'($urandom_range(0, 8)), $urandom, 32'($urandom_range(0, 40)), $urandom);
      if ($urandom_range(0, 7) == 0) begin
        fa[0] = fb[0];
        fop[0] = ALU_SUB;
      end
      cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
